// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the boot-time instruction-memory loader and
//   for any host-side model that builds frames for it.
//   - state_t       : loader FSM states
//   - SYNC_BYTE     : default frame start marker
//   - frame_field_t : order of the fields inside a frame on the wire
//   - frame_bytes() : total wire length of a frame carrying LEN words
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Wire order of a frame. The DATA_LO/DATA_HI pair repeats LEN times.
  typedef enum logic [2:0] {
    FLD_SYNC,
    FLD_LEN_LO,
    FLD_LEN_HI,
    FLD_DATA_LO,
    FLD_DATA_HI,
    FLD_CHK
  } frame_field_t;

  localparam int HDR_BYTES      = 3;
  localparam int BYTES_PER_WORD = 2;
  localparam int CHK_BYTES      = 1;

  // Number of bytes on the wire for a frame that carries len words.
  function automatic int frame_bytes(input int len);
    return HDR_BYTES + BYTES_PER_WORD * len + CHK_BYTES;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time loader for the shared instruction RAM. Accepts a framed byte
//   stream over a valid/ready handshake, assembles 16-bit little-endian
//   words, writes them to consecutive IMEM addresses starting at 0, and
//   keeps the CPU cores in reset until a whole frame has arrived with a
//   good checksum.
//
//   Frame: SYNC, LEN_LO, LEN_HI, LEN x {lo, hi}, CHK
//   CHK is the XOR of every byte from LEN_LO through the last data byte.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   in_data   in   stream byte
//   in_valid  in   in_data is valid
//   in_ready  out  loader takes a byte this cycle (decoded from state only)
//   restart   in   one-cycle pulse, returns DONE/ERROR to IDLE
//   im_addr   out  IMEM write word address
//   im_wdata  out  IMEM write data {hi, lo}
//   im_we     out  IMEM write strobe, one cycle per word
//   cpu_hold  out  high keeps the CPU cores in reset
//   done      out  frame loaded and checksum good
//   err       out  frame rejected (bad length, bad checksum or timeout)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter int         MAX_WORDS   = 256,
  parameter int         TIMEOUT_CYC = 50_000_000,
  parameter logic [7:0] SYNC_BYTE   = imem_loader_pkg::SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              im_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [15:0] MAX_LEN     = 16'(MAX_WORDS);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYC);

  state_t      state;
  state_t      next_state;

  logic        accept;
  logic        running;
  logic        last_word;
  logic        timeout_hit;

  logic [7:0]  len_lo;
  logic [7:0]  lo_byte;
  logic [7:0]  chk_acc;
  logic [15:0] len;
  logic [15:0] len_in;
  logic [15:0] word_cnt;
  logic [31:0] timer;
  logic [31:0] timer_inc;

  // State register. Reset drops the loader straight back to IDLE no matter
  // where it was in a frame; IMEM writes already issued stay in the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Every move inside a frame is driven by an accepted
  // byte, except the timeout which can yank any in-frame state to ERROR.
  // DONE and ERROR only leave on restart so software always sees the result.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          next_state = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          next_state = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          if (len_in == 16'd0) begin
            next_state = ST_CHECK;
          end else if (len_in > MAX_LEN) begin
            next_state = ST_ERROR;
          end else begin
            next_state = ST_DATA_LO;
          end
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          next_state = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          next_state = last_word ? ST_CHECK : ST_DATA_LO;
        end
      end
      ST_CHECK: begin
        if (accept) begin
          next_state = (in_data == chk_acc) ? ST_DONE : ST_ERROR;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (restart) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    if (timeout_hit) begin
      next_state = ST_ERROR;
    end
  end

  // Decodes derived from the current state. in_ready looks at state only so
  // an upstream source may legally wait for ready before raising valid.
  // The timer holds the number of cycles since the last accepted byte,
  // counting the acceptance cycle itself, so the timeout fires on the edge
  // where that count would reach TIMEOUT_CYC.
  always_comb begin
    in_ready    = (state != ST_DONE) && (state != ST_ERROR);
    accept      = in_valid && in_ready;
    running     = (state == ST_LEN_LO)  || (state == ST_LEN_HI) ||
                  (state == ST_DATA_LO) || (state == ST_DATA_HI) ||
                  (state == ST_CHECK);
    len_in      = {in_data, len_lo};
    last_word   = (word_cnt == (len - 16'd1));
    timer_inc   = timer + 32'd1;
    timeout_hit = running && !accept && (timer_inc == TIMEOUT_LIM);
  end

  // Inter-byte timeout counter. It only runs while the next state is inside
  // a frame, reloads on every accepted byte and sits at zero otherwise, so
  // a quiet line in IDLE never raises an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= 32'd0;
    end else if (!((next_state == ST_LEN_LO)  || (next_state == ST_LEN_HI) ||
                   (next_state == ST_DATA_LO) || (next_state == ST_DATA_HI) ||
                   (next_state == ST_CHECK))) begin
      timer <= 32'd0;
    end else if (accept) begin
      timer <= 32'd1;
    end else begin
      timer <= timer_inc;
    end
  end

  // Frame datapath: length capture, running checksum, word assembly and the
  // IMEM write port. The write strobe lasts exactly one cycle after the hi
  // byte, and the address steps on the edge that ends that strobe. The step
  // is skipped after the final word so the address never wraps, even when
  // LEN equals 2^ADDR_W. IDLE clears the counters for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo   <= 8'd0;
      len      <= 16'd0;
      lo_byte  <= 8'd0;
      chk_acc  <= 8'd0;
      word_cnt <= 16'd0;
      im_addr  <= '0;
      im_wdata <= 16'd0;
      im_we    <= 1'b0;
    end else begin
      im_we <= 1'b0;

      if (im_we && (word_cnt < len)) begin
        im_addr <= im_addr + 1'b1;
      end

      if (state == ST_IDLE) begin
        chk_acc  <= 8'd0;
        word_cnt <= 16'd0;
        im_addr  <= '0;
      end

      if (accept) begin
        case (state)
          ST_LEN_LO: begin
            len_lo  <= in_data;
            chk_acc <= chk_acc ^ in_data;
          end
          ST_LEN_HI: begin
            len     <= len_in;
            chk_acc <= chk_acc ^ in_data;
          end
          ST_DATA_LO: begin
            lo_byte <= in_data;
            chk_acc <= chk_acc ^ in_data;
          end
          ST_DATA_HI: begin
            im_we    <= 1'b1;
            im_wdata <= {in_data, lo_byte};
            word_cnt <= word_cnt + 16'd1;
            chk_acc  <= chk_acc ^ in_data;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Status outputs, registered from the state so they rise one cycle after
  // the deciding byte and never glitch. A restart clears them on the same
  // edge that returns the FSM to IDLE, and the cores go back into reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      done     <= (state == ST_DONE) && !restart;
      err      <= (state == ST_ERROR) && !restart;
      cpu_hold <= !((state == ST_DONE) && !restart);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Scoreboard bench for imem_loader. Stimulus tasks push the expected IMEM
//   writes and done/err events (with the cycle they must appear in) into a
//   queue; an independent monitor pops and compares whenever the DUT shows
//   a write strobe or a rising done/err.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W      = 8;
  localparam int MAX_WORDS   = 256;
  localparam int TIMEOUT_CYC = 16;

  localparam int EV_WRITE = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              restart;
  logic [ADDR_W-1:0] im_addr;
  logic [15:0]       im_wdata;
  logic              im_we;
  logic              cpu_hold;
  logic              done;
  logic              err;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [15:0] wd [0:7];
  logic        done_q;
  logic        err_q;

  imem_loader #(
    .ADDR_W      (ADDR_W),
    .MAX_WORDS   (MAX_WORDS),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_BYTE   (SYNC_BYTE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .restart  (restart),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .im_we    (im_we),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input int kind, input logic [7:0] addr,
                         input logic [15:0] data, input int at_cyc);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.cyc  = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic expectEvent(input int kind, input string name);
    exp_t e;
    checkOutput({name, "_pending"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({name, "_kind"}, 32'(kind), 32'(e.kind));
      checkOutput({name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      if (kind == EV_WRITE) begin
        checkOutput({name, "_addr"}, 32'(im_addr), 32'(e.addr));
        checkOutput({name, "_data"}, 32'(im_wdata), 32'(e.data));
      end else if (kind == EV_DONE) begin
        checkOutput({name, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
      end else begin
        checkOutput({name, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (im_we) expectEvent(EV_WRITE, "write");
      if (done && !done_q) expectEvent(EV_DONE, "done_rise");
      if (err && !err_q) expectEvent(EV_ERR, "err_rise");
      done_q <= done;
      err_q  <= err;
    end
  end

  // Sends one byte after gap idle cycles; acc returns the cycle number of
  // the edge that accepted it.
  task automatic applyStimulus(input logic [7:0] b, input int gap, output int acc);
    int tries;
    acc = -1;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    tries = 0;
    while (!in_ready && tries < 8) begin
      @(negedge clk);
      tries++;
    end
    checkOutput("in_ready_for_byte", 32'(in_ready), 32'd1);
    if (in_ready) begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic sendFrame(input int len, input logic [7:0] chk,
                           input bit good, input int max_gap);
    int acc;
    applyStimulus(SYNC_BYTE, $urandom_range(0, max_gap), acc);
    applyStimulus(8'(len), $urandom_range(0, max_gap), acc);
    applyStimulus(8'(len >> 8), $urandom_range(0, max_gap), acc);
    for (int i = 0; i < len; i++) begin
      applyStimulus(wd[i][7:0], $urandom_range(0, max_gap), acc);
      applyStimulus(wd[i][15:8], $urandom_range(0, max_gap), acc);
      pushExp(EV_WRITE, 8'(i), wd[i], acc);
    end
    applyStimulus(chk, $urandom_range(0, max_gap), acc);
    pushExp(good ? EV_DONE : EV_ERR, 8'h00, 16'h0000, acc + 1);
  endtask

  task automatic checkDrained(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput({"drained_", name}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulseRestart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    restart  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_im_we", 32'(im_we), 32'd0);
    checkOutput("rst_im_addr", 32'(im_addr), 32'd0);
    checkOutput("rst_im_wdata", 32'(im_wdata), 32'd0);
    checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] nominal load");
    wd[0] = 16'h2211; wd[1] = 16'h4433; wd[2] = 16'h6655;
    sendFrame(3, 8'h74, 1'b1, 0);
    checkDrained("nominal");
    checkOutput("nominal_done", 32'(done), 32'd1);
    checkOutput("nominal_cpu_hold", 32'(cpu_hold), 32'd0);
    checkOutput("nominal_in_ready", 32'(in_ready), 32'd0);
    checkOutput("nominal_last_addr", 32'(im_addr), 32'd2);
    pulseRestart();
    checkOutput("restart_done_clr", 32'(done), 32'd0);
    checkOutput("restart_hold_set", 32'(cpu_hold), 32'd1);
    checkOutput("restart_ready", 32'(in_ready), 32'd1);

    $display("[TB] bad checksum");
    sendFrame(3, 8'h75, 1'b0, 0);
    checkDrained("badchk");
    checkOutput("badchk_err", 32'(err), 32'd1);
    checkOutput("badchk_done", 32'(done), 32'd0);
    checkOutput("badchk_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("badchk_in_ready", 32'(in_ready), 32'd0);
    pulseRestart();
    checkOutput("badchk_restart_err", 32'(err), 32'd0);
    checkOutput("badchk_restart_ready", 32'(in_ready), 32'd1);
    checkOutput("badchk_restart_hold", 32'(cpu_hold), 32'd1);

    $display("[TB] oversize length");
    applyStimulus(SYNC_BYTE, 0, acc);
    applyStimulus(8'h01, 0, acc);
    applyStimulus(8'h01, 0, acc);
    pushExp(EV_ERR, 8'h00, 16'h0000, acc + 1);
    checkDrained("oversize");
    checkOutput("oversize_err", 32'(err), 32'd1);
    pulseRestart();

    $display("[TB] garbage then empty frame");
    applyStimulus(8'h00, 0, acc);
    applyStimulus(8'hFF, 0, acc);
    applyStimulus(8'hA4, 0, acc);
    sendFrame(0, 8'h00, 1'b1, 0);
    checkDrained("len0");
    checkOutput("len0_done", 32'(done), 32'd1);
    checkOutput("len0_cpu_hold", 32'(cpu_hold), 32'd0);
    pulseRestart();

    $display("[TB] timeout mid-word");
    applyStimulus(SYNC_BYTE, 0, acc);
    applyStimulus(8'h01, 0, acc);
    applyStimulus(8'h00, 0, acc);
    applyStimulus(8'h77, 0, acc);
    pushExp(EV_ERR, 8'h00, 16'h0000, acc + TIMEOUT_CYC);
    checkDrained("timeout");
    checkOutput("timeout_err", 32'(err), 32'd1);
    pulseRestart();

    $display("[TB] backpressure");
    wd[0] = 16'hBEEF; wd[1] = 16'h1234; wd[2] = 16'hA55A; wd[3] = 16'h0F0F;
    sendFrame(4, 8'h8C, 1'b1, 3);
    checkDrained("backpressure");
    checkOutput("backpressure_done", 32'(done), 32'd1);
    pulseRestart();

    $display("[TB] reset mid-frame");
    applyStimulus(SYNC_BYTE, 0, acc);
    applyStimulus(8'h03, 0, acc);
    applyStimulus(8'h00, 0, acc);
    applyStimulus(8'h57, 0, acc);
    applyStimulus(8'h13, 0, acc);
    pushExp(EV_WRITE, 8'h00, 16'h1357, acc);
    applyStimulus(8'h68, 0, acc);
    applyStimulus(8'h24, 0, acc);
    pushExp(EV_WRITE, 8'h01, 16'h2468, acc);
    @(negedge clk);
    #1;
    checkOutput("prereset_im_we", 32'(im_we), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_im_we", 32'(im_we), 32'd0);
    checkOutput("async_im_addr", 32'(im_addr), 32'd0);
    checkOutput("async_im_wdata", 32'(im_wdata), 32'd0);
    checkOutput("async_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("async_done", 32'(done), 32'd0);
    checkOutput("async_err", 32'(err), 32'd0);
    checkOutput("async_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] recovery load after reset");
    wd[0] = 16'hCAFE;
    sendFrame(1, 8'h35, 1'b1, 0);
    checkDrained("recovery");
    checkOutput("recovery_done", 32'(done), 32'd1);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
